// File: rtl/usb_tx_phy.sv
// Full-speed USB transmit line driver: serialises handshake bytes with SYNC, bit stuffing,
// NRZI and EOP onto the D+/D- pads.
module usb_tx_phy #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       usb_reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_active,
  output logic       usb_oe,
  output logic       usb_dp,
  output logic       usb_dn
);

  localparam int unsigned PhaseW = $clog2(CLKS_PER_BIT);
  localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(CLKS_PER_BIT - 1);
  localparam logic [7:0] SyncPattern = 8'h80;

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StData,
    StStuff,
    StEopSe0,
    StEopJ
  } state_e;

  state_e            state_q, state_d;
  logic [PhaseW-1:0] phase_q, phase_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [2:0]        stuff_cnt_q, stuff_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              ready_q, ready_d;
  logic              oe_q, oe_d;
  logic              dp_q, dp_d;
  logic              dn_q, dn_d;

  logic tick;
  logic send_en;
  logic send_bit;

  assign tick = (phase_q == PhaseLast);

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    bit_cnt_d   = bit_cnt_q;
    stuff_cnt_d = stuff_cnt_q;
    shift_d     = shift_q;
    ready_d     = 1'b0;
    oe_d        = oe_q;
    dp_d        = dp_q;
    dn_d        = dn_q;
    send_en     = 1'b0;
    send_bit    = 1'b0;

    if (state_q != StIdle) begin
      phase_d = tick ? '0 : phase_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (tx_valid) begin
          state_d   = StSync;
          phase_d   = '0;
          bit_cnt_d = 3'd0;
          shift_d   = SyncPattern;
          oe_d      = 1'b1;
          send_en   = 1'b1;
          send_bit  = SyncPattern[0];
        end
      end
      // shift_q[0] is the bit currently on the line; a stuff bit leaves it in place
      StSync, StData, StStuff: begin
        if (tick) begin
          if (stuff_cnt_q == 3'd6) begin
            state_d  = StStuff;
            send_en  = 1'b1;
            send_bit = 1'b0;
          end else if (bit_cnt_q != 3'd7) begin
            state_d   = (state_q == StSync) ? StSync : StData;
            shift_d   = {1'b0, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            send_en   = 1'b1;
            send_bit  = shift_q[1];
          end else if (tx_valid) begin
            state_d   = StData;
            shift_d   = tx_data;
            bit_cnt_d = 3'd0;
            ready_d   = 1'b1;
            send_en   = 1'b1;
            send_bit  = tx_data[0];
          end else begin
            state_d     = StEopSe0;
            bit_cnt_d   = 3'd0;
            stuff_cnt_d = 3'd0;
            dp_d        = 1'b0;
            dn_d        = 1'b0;
          end
        end
      end
      StEopSe0: begin
        if (tick) begin
          if (bit_cnt_q == 3'd1) begin
            state_d   = StEopJ;
            bit_cnt_d = 3'd0;
            dp_d      = 1'b1;
            dn_d      = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      StEopJ: begin
        if (tick) begin
          state_d = StIdle;
          phase_d = '0;
          shift_d = 8'h00;
          oe_d    = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // NRZI: a 0 toggles the line, a 1 holds it; the stuff counter tracks the run of 1s
    if (send_en) begin
      dp_d        = send_bit ? dp_q : ~dp_q;
      dn_d        = ~dp_d;
      stuff_cnt_d = send_bit ? stuff_cnt_q + 3'd1 : 3'd0;
    end
  end

  always_ff @(posedge clk or posedge usb_reset) begin
    if (usb_reset) begin
      state_q     <= StIdle;
      phase_q     <= '0;
      bit_cnt_q   <= 3'd0;
      stuff_cnt_q <= 3'd0;
      shift_q     <= 8'h00;
      ready_q     <= 1'b0;
      oe_q        <= 1'b0;
      dp_q        <= 1'b1;
      dn_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bit_cnt_q   <= bit_cnt_d;
      stuff_cnt_q <= stuff_cnt_d;
      shift_q     <= shift_d;
      ready_q     <= ready_d;
      oe_q        <= oe_d;
      dp_q        <= dp_d;
      dn_q        <= dn_d;
    end
  end

  assign tx_ready  = ready_q;
  assign tx_active = oe_q;
  assign usb_oe    = oe_q;
  assign usb_dp    = dp_q;
  assign usb_dn    = dn_q;

endmodule

// File: tb/tb_usb_tx_phy.sv
// Bench for usb_tx_phy: packet table driven into two instances (4 and 2 clk/bit); the line is
// decoded (NRZI + destuff) and checked against a scoreboard of the bytes offered.
module tb_usb_tx_phy;

  logic       clk = 1'b0;
  logic       usb_reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  int         dut_sel = 0;

  logic valid_a, rdy_a, act_a, oe_a, dp_a, dn_a;
  logic valid_b, rdy_b, act_b, oe_b, dp_b, dn_b;
  logic rdy_s, act_s, oe_s, dp_s, dn_s;

  assign valid_a = tx_valid && (dut_sel == 0);
  assign valid_b = tx_valid && (dut_sel == 1);
  assign rdy_s   = (dut_sel == 0) ? rdy_a : rdy_b;
  assign act_s   = (dut_sel == 0) ? act_a : act_b;
  assign oe_s    = (dut_sel == 0) ? oe_a : oe_b;
  assign dp_s    = (dut_sel == 0) ? dp_a : dp_b;
  assign dn_s    = (dut_sel == 0) ? dn_a : dn_b;

  always #5 clk = ~clk;

  usb_tx_phy u_dut_a (
    .clk      (clk),
    .usb_reset(usb_reset),
    .tx_data  (tx_data),
    .tx_valid (valid_a),
    .tx_ready (rdy_a),
    .tx_active(act_a),
    .usb_oe   (oe_a),
    .usb_dp   (dp_a),
    .usb_dn   (dn_a)
  );

  usb_tx_phy #(.CLKS_PER_BIT(2)) u_dut_b (
    .clk      (clk),
    .usb_reset(usb_reset),
    .tx_data  (tx_data),
    .tx_valid (valid_b),
    .tx_ready (rdy_b),
    .tx_active(act_b),
    .usb_oe   (oe_b),
    .usb_dp   (dp_b),
    .usb_dn   (dn_b)
  );

  typedef struct {
    int         sel;
    int         cpb;
    int         n;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    int         oe_len;
    int         se0_bit;
    int         stuffs;
  } vec_t;

  int         n_pass = 0;
  int         n_total = 0;
  logic [1:0] samp_q[$];
  int         ready_at[$];
  logic [7:0] exp_q[$];
  int         stray_ready;
  int         act_mismatch;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic run_packet(input vec_t v);
    logic [7:0] bs[3];
    int idx, cyc;
    bit started, done;
    bs[0] = v.b0; bs[1] = v.b1; bs[2] = v.b2;
    idx = 0; cyc = 0; started = 0; done = 0;
    stray_ready = 0; act_mismatch = 0;
    samp_q.delete();
    ready_at.delete();
    dut_sel = v.sel;
    @(negedge clk);
    tx_data  = bs[0];
    tx_valid = 1'b1;
    exp_q.push_back(bs[0]);
    while (!done && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (act_s !== oe_s) act_mismatch++;
      if (rdy_s && !oe_s) stray_ready++;
      if (oe_s) begin
        started = 1;
        samp_q.push_back({dp_s, dn_s});
        if (rdy_s) begin
          ready_at.push_back(samp_q.size() - 1);
          idx++;
          if (idx < v.n) begin
            tx_data = bs[idx];
            exp_q.push_back(bs[idx]);
          end else begin
            tx_valid = 1'b0;
          end
        end
      end else if (started) begin
        done = 1;
      end
    end
    tx_valid = 1'b0;
    check("packet_done", int'(done), 1);
    check("active_eq_oe", act_mismatch, 0);
    check("stray_ready", stray_ready, 0);
  endtask

  task automatic analyze(input vec_t v);
    int nbits, unstable, se0_at, illegal, ones, stuffs, stuff_err, nb;
    logic [1:0] prev, lv;
    logic [7:0] sync_byte, cur, e;
    logic d;
    unstable = 0; se0_at = -1; illegal = 0; ones = 0; stuffs = 0; stuff_err = 0; nb = 0;
    prev = 2'b10; sync_byte = 8'h00; cur = 8'h00;
    check("oe_len", samp_q.size(), v.oe_len);
    nbits = samp_q.size() / v.cpb;
    for (int i = 0; i < nbits; i++) begin
      for (int j = 1; j < v.cpb; j++) begin
        if (samp_q[i*v.cpb+j] != samp_q[i*v.cpb]) unstable++;
      end
    end
    check("bit_stable", unstable, 0);
    for (int i = 0; i < nbits; i++) begin
      if (se0_at < 0) begin
        lv = samp_q[i*v.cpb];
        if (lv == 2'b00) begin
          se0_at = i;
        end else begin
          if (lv != 2'b10 && lv != 2'b01) illegal++;
          d = (lv == prev);
          prev = lv;
          if (i < 8) sync_byte[i] = d;
          if (ones == 6) begin
            stuffs++;
            if (d) stuff_err++;
            ones = 0;
          end else begin
            ones = d ? ones + 1 : 0;
            if (i >= 8) begin
              cur[nb] = d;
              nb++;
              if (nb == 8) begin
                nb = 0;
                if (exp_q.size() == 0) begin
                  check("sb_underflow", 1, 0);
                end else begin
                  e = exp_q.pop_front();
                  check("decoded_byte", int'(cur), int'(e));
                end
              end
            end
          end
        end
      end
    end
    check("sync_byte", int'(sync_byte), 8'h80);
    check("illegal_line", illegal, 0);
    check("se0_bit", se0_at, v.se0_bit);
    check("stuff_count", stuffs, v.stuffs);
    check("stuff_polarity", stuff_err, 0);
    check("partial_bits", nb, 0);
    check("sb_leftover", exp_q.size(), 0);
    exp_q.delete();
    if (se0_at >= 0 && nbits >= se0_at + 3) begin
      check("eop_se0_2nd", int'(samp_q[(se0_at+1)*v.cpb]), 0);
      check("eop_j", int'(samp_q[(se0_at+2)*v.cpb]), 2);
    end else begin
      check("eop_present", 0, 1);
    end
    check("ready_count", ready_at.size(), v.n);
    for (int k = 0; k < ready_at.size() && k < v.n; k++) begin
      check("ready_time", ready_at[k], 8 * v.cpb * (k + 1));
    end
  endtask

  vec_t vecs[5];

  initial begin
    int oe_seen, not_j;
    vecs[0] = '{0, 4, 1, 8'h00, 8'h00, 8'h00, 76, 16, 0};
    vecs[1] = '{0, 4, 1, 8'hFF, 8'h00, 8'h00, 80, 17, 1};
    vecs[2] = '{0, 4, 2, 8'h00, 8'hFC, 8'h00, 112, 25, 1};
    vecs[3] = '{0, 4, 3, 8'hC3, 8'h5A, 8'hA5, 140, 32, 0};
    vecs[4] = '{1, 2, 1, 8'h00, 8'h00, 8'h00, 38, 16, 0};

    repeat (3) @(negedge clk);
    check("rst_oe", int'(oe_a), 0);
    check("rst_line", int'({dp_a, dn_a}), 2);
    check("rst_ready_active", int'({rdy_a, act_a}), 0);
    usb_reset = 1'b0;
    repeat (3) @(negedge clk);

    for (int t = 0; t < 5; t++) begin
      run_packet(vecs[t]);
      analyze(vecs[t]);
      repeat (4) @(negedge clk);
    end

    // Abort mid-DATA: reset must drop the pads to idle J in the same clock, no EOP
    dut_sel = 0;
    @(negedge clk);
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    repeat (45) @(negedge clk);
    check("oe_before_abort", int'(oe_a), 1);
    #2;
    usb_reset = 1'b1;
    #1;
    check("abort_oe", int'(oe_a), 0);
    check("abort_line", int'({dp_a, dn_a}), 2);
    check("abort_ready", int'(rdy_a), 0);
    tx_valid = 1'b0;
    @(negedge clk);
    usb_reset = 1'b0;
    oe_seen = 0; not_j = 0;
    repeat (20) begin
      @(negedge clk);
      if (oe_a) oe_seen++;
      if ({dp_a, dn_a} != 2'b10) not_j++;
    end
    check("post_abort_idle_oe", oe_seen, 0);
    check("post_abort_idle_j", not_j, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
